// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter sharing one UART transmitter among N_REQ byte producers.
// Holds the grant for a whole frame; a watchdog aborts frames whose done tick never arrives.
module uart_tx_arbiter #(
  parameter int unsigned NB_DATA        = 8,
  parameter int unsigned N_REQ          = 2,
  parameter int unsigned TIMEOUT_CYCLES = 32768
) (
  input  logic                     i_clock,
  input  logic                     i_reset,
  input  logic [N_REQ-1:0]         i_req,
  input  logic [N_REQ*NB_DATA-1:0] i_data,
  output logic [N_REQ-1:0]         o_ack,
  output logic [N_REQ-1:0]         o_grant,
  output logic                     o_tx_ready,
  output logic [NB_DATA-1:0]       o_tx_data,
  input  logic                     i_tx_done_tick,
  output logic                     o_busy,
  output logic                     o_timeout
);

  localparam int unsigned IDX_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;
  localparam int unsigned WD_W  = $clog2(TIMEOUT_CYCLES);
  localparam logic [WD_W-1:0]  WD_LAST  = WD_W'(TIMEOUT_CYCLES - 1);
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(N_REQ - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_START,
    S_WAIT
  } state_t;

  state_t              state;
  logic [IDX_W-1:0]    last;
  logic [IDX_W-1:0]    owner;
  logic [WD_W-1:0]     wdog;

  logic                win_valid;
  logic [IDX_W-1:0]    win_idx;
  logic [IDX_W-1:0]    cand;
  logic [N_REQ-1:0]    win_onehot;
  logic [NB_DATA-1:0]  win_byte;

  // Winner search starts just after the last owner and wraps around.
  always_comb begin
    win_valid = 1'b0;
    win_idx   = '0;
    cand      = '0;
    for (int unsigned i = 1; i <= N_REQ; i++) begin
      cand = IDX_W'((32'(last) + i) % N_REQ);
      if (!win_valid && i_req[cand]) begin
        win_valid = 1'b1;
        win_idx   = cand;
      end
    end
  end

  always_comb begin
    win_byte = '0;
    for (int unsigned k = 0; k < N_REQ; k++) begin
      if (win_idx == IDX_W'(k)) begin
        win_byte = i_data[k*NB_DATA +: NB_DATA];
      end
    end
  end

  assign win_onehot = {{(N_REQ-1){1'b0}}, 1'b1} << win_idx;

  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      state      <= S_IDLE;
      last       <= IDX_LAST;
      owner      <= '0;
      wdog       <= '0;
      o_ack      <= '0;
      o_grant    <= '0;
      o_tx_ready <= 1'b0;
      o_tx_data  <= '0;
      o_busy     <= 1'b0;
      o_timeout  <= 1'b0;
    end else begin
      o_ack      <= '0;
      o_tx_ready <= 1'b0;
      o_timeout  <= 1'b0;
      case (state)
        S_IDLE: begin
          if (win_valid) begin
            owner      <= win_idx;
            o_grant    <= win_onehot;
            o_ack      <= win_onehot;
            o_tx_data  <= win_byte;
            o_tx_ready <= 1'b1;
            o_busy     <= 1'b1;
            state      <= S_START;
          end
        end
        S_START: begin
          wdog  <= '0;
          state <= S_WAIT;
        end
        S_WAIT: begin
          // Done tick takes precedence over a coincident watchdog expiry.
          if (i_tx_done_tick) begin
            last    <= owner;
            o_grant <= '0;
            o_busy  <= 1'b0;
            state   <= S_IDLE;
          end else if (wdog == WD_LAST) begin
            o_timeout <= 1'b1;
            last      <= owner;
            o_grant   <= '0;
            o_busy    <= 1'b0;
            state     <= S_IDLE;
          end else begin
            wdog <= wdog + WD_W'(1);
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Bench for uart_tx_arbiter: directed scenarios plus randomized traffic,
// every cycle compared against a frame-level reference model.
module tb_uart_tx_arbiter;

  localparam int unsigned NB = 8;
  localparam int unsigned NR = 2;
  localparam int unsigned TO = 64;

  logic            clk = 1'b0;
  logic            rst;
  logic [NR-1:0]   req;
  logic [NR*NB-1:0] din;
  logic            tick;
  logic [NR-1:0]   o_ack;
  logic [NR-1:0]   o_grant;
  logic            o_tx_ready;
  logic [NB-1:0]   o_tx_data;
  logic            o_busy;
  logic            o_timeout;

  int n_total = 0;
  int n_bad   = 0;

  // reference model: a frame in flight plus its age in cycles since the start pulse
  bit          m_active;
  int          m_last, m_owner, m_age;
  logic [NR-1:0] e_ack, e_grant;
  logic        e_ready, e_busy, e_to;
  logic [NB-1:0] e_data;

  uart_tx_arbiter #(
    .NB_DATA(NB), .N_REQ(NR), .TIMEOUT_CYCLES(TO)
  ) dut (
    .i_clock(clk), .i_reset(rst), .i_req(req), .i_data(din),
    .o_ack(o_ack), .o_grant(o_grant), .o_tx_ready(o_tx_ready),
    .o_tx_data(o_tx_data), .i_tx_done_tick(tick), .o_busy(o_busy),
    .o_timeout(o_timeout)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  function automatic void model_update();
    if (rst) begin
      m_active = 0; m_last = NR - 1; m_owner = 0; m_age = 0;
      e_ack = '0; e_grant = '0; e_ready = 0; e_busy = 0; e_to = 0; e_data = '0;
      return;
    end
    e_ack = '0; e_ready = 0; e_to = 0;
    if (!m_active) begin
      for (int i = 1; i <= NR; i++) begin
        int k;
        k = (m_last + i) % NR;
        if (!m_active && req[k]) begin
          m_active = 1; m_owner = k; m_age = 0;
          e_ack = NR'(1) << k; e_grant = NR'(1) << k;
          e_ready = 1; e_busy = 1; e_data = din[k*NB +: NB];
        end
      end
    end else if (m_age == 0) begin
      m_age = 1;
    end else if (tick) begin
      m_active = 0; m_last = m_owner; e_grant = '0; e_busy = 0;
    end else if (m_age == TO) begin
      m_active = 0; m_last = m_owner; e_grant = '0; e_busy = 0; e_to = 1;
    end else begin
      m_age++;
    end
  endfunction

  task automatic step();
    @(posedge clk);
    model_update();
    #1;
    check_eq("ack",     32'(o_ack),      32'(e_ack));
    check_eq("grant",   32'(o_grant),    32'(e_grant));
    check_eq("ready",   32'(o_tx_ready), 32'(e_ready));
    check_eq("data",    32'(o_tx_data),  32'(e_data));
    check_eq("busy",    32'(o_busy),     32'(e_busy));
    check_eq("timeout", 32'(o_timeout),  32'(e_to));
  endtask

  task automatic cyc(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  task automatic do_reset();
    rst = 1'b1; step(); rst = 1'b0;
  endtask

  logic [7:0] rr_exp_data [4];
  logic [1:0] rr_exp_ack  [4];
  int         quiet;
  int         n_steps;
  int         n_pulses;
  bit         seen;

  initial begin
    rst = 1'b1; req = '0; din = '0; tick = 1'b0;
    step(); step();
    rst = 1'b0;
    check_eq("rst_grant", 32'(o_grant), 32'h0);
    check_eq("rst_busy",  32'(o_busy),  32'h0);

    // single request with 0xA5, done tick 100 cycles later
    req = 2'b01; din[7:0] = 8'hA5;
    step();
    check_eq("a5_ack",   32'(o_ack),      32'h1);
    check_eq("a5_ready", 32'(o_tx_ready), 32'h1);
    check_eq("a5_data",  32'(o_tx_data),  32'hA5);
    check_eq("a5_grant", 32'(o_grant),    32'h1);
    req = 2'b00;
    cyc(99);
    tick = 1'b1; step(); tick = 1'b0;
    check_eq("a5_busy_after", 32'(o_busy),  32'h0);
    check_eq("a5_grant_after", 32'(o_grant), 32'h0);

    // both requesters held: strict alternation from requester 0
    do_reset();
    rr_exp_data = '{8'h11, 8'h22, 8'h11, 8'h22};
    rr_exp_ack  = '{2'b01, 2'b10, 2'b01, 2'b10};
    req = 2'b11; din = {8'h22, 8'h11};
    for (int f = 0; f < 4; f++) begin
      seen = 0;
      for (int i = 0; i < 10; i++) begin
        step();
        if (o_tx_ready) begin seen = 1; break; end
      end
      check_eq("rr_ready_seen", 32'(seen), 32'h1);
      check_eq("rr_data", 32'(o_tx_data), 32'(rr_exp_data[f]));
      check_eq("rr_ack",  32'(o_ack),     32'(rr_exp_ack[f]));
      cyc(5);
      tick = 1'b1; step(); tick = 1'b0;
    end
    req = 2'b00;

    // request from 1 raised during 0's WAIT is deferred
    do_reset();
    req = 2'b01; din = {8'h5C, 8'h3B};
    step();
    req = 2'b10;
    n_pulses = 0;
    for (int i = 0; i < 20; i++) begin
      step();
      if (o_ack != 2'b00) n_pulses++;
    end
    check_eq("defer_no_ack", 32'(n_pulses), 32'h0);
    tick = 1'b1; step(); tick = 1'b0;
    check_eq("defer_idle_ack", 32'(o_ack), 32'h0);
    step();
    check_eq("defer_ack1", 32'(o_ack),     32'h2);
    check_eq("defer_data", 32'(o_tx_data), 32'h5C);
    req = 2'b00;
    cyc(3);
    tick = 1'b1; step(); tick = 1'b0;

    // watchdog: no done tick at all
    do_reset();
    req = 2'b01;
    step();
    check_eq("to_start", 32'(o_tx_ready), 32'h1);
    req = 2'b00;
    seen = 0; n_steps = 0;
    for (int i = 0; i < 100 && !seen; i++) begin
      step(); n_steps++;
      if (o_timeout) seen = 1;
    end
    check_eq("to_seen", 32'(seen),    32'h1);
    check_eq("to_dist", 32'(n_steps), 32'd65);
    n_pulses = 0;
    for (int i = 0; i < 10; i++) begin
      step();
      if (o_timeout) n_pulses++;
    end
    check_eq("to_once", 32'(n_pulses), 32'h0);
    req = 2'b11;
    step();
    check_eq("to_next_ack", 32'(o_ack), 32'h2);
    req = 2'b00;
    cyc(2);
    tick = 1'b1; step(); tick = 1'b0;

    // stray done ticks in IDLE and START
    do_reset();
    tick = 1'b1; step(); tick = 1'b0;
    check_eq("stray_idle_busy", 32'(o_busy), 32'h0);
    req = 2'b01; step();
    req = 2'b00; tick = 1'b1; step(); tick = 1'b0;
    check_eq("stray_start_busy", 32'(o_busy), 32'h1);
    cyc(3);
    check_eq("stray_still_busy", 32'(o_grant), 32'h1);
    tick = 1'b1; step(); tick = 1'b0;

    // reset in the middle of requester 1's frame
    do_reset();
    req = 2'b10; step();
    req = 2'b00; cyc(5);
    check_eq("mid_grant", 32'(o_grant), 32'h2);
    rst = 1'b1; step(); rst = 1'b0;
    check_eq("mid_rst_outs",
             32'({o_ack, o_grant, o_tx_ready, o_tx_data, o_busy, o_timeout}), 32'h0);
    req = 2'b11; step();
    check_eq("mid_first", 32'(o_ack), 32'h1);
    req = 2'b00;
    cyc(2);
    tick = 1'b1; step(); tick = 1'b0;

    // randomized traffic honouring the requester contract
    quiet = 0;
    for (int c = 0; c < 4000; c++) begin
      step();
      for (int k = 0; k < NR; k++) begin
        if (e_ack[k]) begin
          if ($urandom_range(1, 0) == 0) req[k] = 1'b0;
          else din[k*NB +: NB] = 8'($urandom);
        end else if (!req[k] && $urandom_range(3, 0) == 0) begin
          req[k] = 1'b1;
          din[k*NB +: NB] = 8'($urandom);
        end
      end
      if (quiet > 0) begin
        tick = 1'b0; quiet--;
      end else begin
        tick = ($urandom_range(9, 0) == 0);
        if ($urandom_range(299, 0) == 0) quiet = 90;
      end
      rst = ($urandom_range(599, 0) == 0);
    end

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
